// File: rtl/hazard_pkg.sv
// Shared constants for the scoreboard-based hazard controller.
//   REG_W          width of a register code
//   REG_PC         register code of the program counter
//   ST_IDLE/FLUSH  flush sequencer state encodings
package hazard_pkg;

  localparam int unsigned REG_W = 4;
  localparam logic [REG_W-1:0] REG_PC = 4'hF;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_FLUSH = 1'b1;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StFlush = ST_FLUSH
  } flush_state_e;

endpackage

// File: rtl/hazard_sb_match.sv
// Combinational comparator of NUM_SRC source operands against a WB_DEPTH-entry
// pending-write scoreboard.
//   src_code_i  packed source codes, operand k at [4k+3:4k]
//   src_vld_i   per-operand valid
//   sb_vld_i    per-entry valid, entry 0 is the youngest
//   sb_code_i   packed entry codes, entry j at [4j+3:4j]
//   hit_o       per-operand hazard hit
//   fwd_sel_o   (HAZARD_FWD_EN only) per-operand 1+j of the youngest
//               matching entry with j>=1, 0 when none
// Build option HAZARD_FWD_EN: only sb[0] matches count as hits; older matches
// are reported as forward selects instead.
module hazard_sb_match
  import hazard_pkg::*;
#(
  parameter int unsigned WB_DEPTH = 2,
  parameter int unsigned NUM_SRC  = 3,
  parameter int unsigned FW       = 2
) (
  input  logic [REG_W*NUM_SRC-1:0]  src_code_i,
  input  logic [NUM_SRC-1:0]        src_vld_i,
  input  logic [WB_DEPTH-1:0]       sb_vld_i,
  input  logic [REG_W*WB_DEPTH-1:0] sb_code_i,
`ifdef HAZARD_FWD_EN
  output logic [NUM_SRC*FW-1:0]     fwd_sel_o,
`endif
  output logic [NUM_SRC-1:0]        hit_o
);

  always_comb begin
    hit_o = '0;
`ifdef HAZARD_FWD_EN
    fwd_sel_o = '0;
`endif
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      // Walk oldest to youngest so the youngest match is the last one written.
      for (int j = int'(WB_DEPTH) - 1; j >= 0; j--) begin
        if (src_vld_i[k] && sb_vld_i[j] &&
            (src_code_i[k*REG_W +: REG_W] == sb_code_i[j*REG_W +: REG_W])) begin
`ifdef HAZARD_FWD_EN
          if (j == 0) hit_o[k] = 1'b1;
          else        fwd_sel_o[k*FW +: FW] = FW'(j + 1);
`else
          hit_o[k] = 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Pipeline hazard controller with a pending-write scoreboard, multi-cycle
// branch-flush sequencer, multiple hold requesters and IRQ deferral.
//   i_clk, i_rst_n    clock, synchronous active-low reset
//   i_irq_flag        IRQ request from EX
//   i_pc_en           PC write (branch taken)
//   i_ex_rd_vld/code  destination of the instruction entering write stages
//   i_src_code/vld    packed source operands and their valids
//   i_hold_req        hold requests
//   o_id_flush, o_ex_flush, o_bubble, o_pipelinehold, o_irq_take
//   o_fwd_sel         per-operand forward select (HAZARD_FWD_EN only)
// Build option HAZARD_FWD_EN adds forwarding from entries j>=1.
module hazard_ctrl_sb
  import hazard_pkg::*;
#(
  parameter int unsigned WB_DEPTH     = 2,
  parameter int unsigned NUM_SRC      = 3,
  parameter int unsigned NUM_HOLD     = 2,
  parameter int unsigned FLUSH_CYCLES = 1,
  localparam int unsigned FW          = $clog2(WB_DEPTH + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_irq_flag,
  input  logic                     i_pc_en,
  input  logic                     i_ex_rd_vld,
  input  logic [REG_W-1:0]         i_ex_rd_code,
  input  logic [REG_W*NUM_SRC-1:0] i_src_code,
  input  logic [NUM_SRC-1:0]       i_src_vld,
  input  logic [NUM_HOLD-1:0]      i_hold_req,
`ifdef HAZARD_FWD_EN
  output logic [NUM_SRC*FW-1:0]    o_fwd_sel,
`endif
  output logic                     o_id_flush,
  output logic                     o_ex_flush,
  output logic                     o_bubble,
  output logic                     o_pipelinehold,
  output logic                     o_irq_take
);

  localparam bit         UseSeq  = (FLUSH_CYCLES > 1);
  localparam logic [3:0] CntLoad = UseSeq ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  logic [WB_DEPTH-1:0]       sb_vld_q, sb_vld_d;
  logic [REG_W*WB_DEPTH-1:0] sb_code_q, sb_code_d;
  flush_state_e              state_q;
  logic [3:0]                cnt_q;
  logic                      irq_pend_q;

  logic                      hold, flush_b, hazard_wb_b, hazard_data, irq_take, ex_flush;
  logic [NUM_SRC-1:0]        src_hit;
`ifdef HAZARD_FWD_EN
  logic [NUM_SRC*FW-1:0]     fwd_sel;
`endif

  hazard_sb_match #(
    .WB_DEPTH (WB_DEPTH),
    .NUM_SRC  (NUM_SRC),
    .FW       (FW)
  ) u_match (
    .src_code_i (i_src_code),
    .src_vld_i  (i_src_vld),
    .sb_vld_i   (sb_vld_q),
    .sb_code_i  (sb_code_q),
`ifdef HAZARD_FWD_EN
    .fwd_sel_o  (fwd_sel),
`endif
    .hit_o      (src_hit)
  );

  always_comb begin
    hazard_wb_b = 1'b0;
    for (int j = 0; j < int'(WB_DEPTH); j++) begin
      if (sb_vld_q[j] && (sb_code_q[j*REG_W +: REG_W] == REG_PC)) hazard_wb_b = 1'b1;
    end
  end

  assign hold        = |i_hold_req;
  assign hazard_data = |src_hit;
  assign flush_b     = i_pc_en | (state_q == StFlush);
  assign irq_take    = (i_irq_flag | irq_pend_q) & ~hold & ~flush_b;
  assign ex_flush    = flush_b | hazard_wb_b | hazard_data | irq_take | hold;

  // Outputs are forced low while reset is asserted so stray inputs never leak.
  assign o_id_flush     = i_rst_n & flush_b;
  assign o_ex_flush     = i_rst_n & ex_flush;
  assign o_bubble       = i_rst_n & hazard_data & ~flush_b;
  assign o_pipelinehold = i_rst_n & hold;
  assign o_irq_take     = i_rst_n & irq_take;
`ifdef HAZARD_FWD_EN
  assign o_fwd_sel      = i_rst_n ? fwd_sel : '0;
`endif

  // Scoreboard shift; a flushed instruction never becomes a pending write.
  always_comb begin
    sb_vld_d  = sb_vld_q;
    sb_code_d = sb_code_q;
    if (!hold) begin
      for (int j = int'(WB_DEPTH) - 1; j >= 1; j--) begin
        sb_vld_d[j]                 = sb_vld_q[j-1];
        sb_code_d[j*REG_W +: REG_W] = sb_code_q[(j-1)*REG_W +: REG_W];
      end
      sb_vld_d[0]          = i_ex_rd_vld & ~ex_flush;
      sb_code_d[REG_W-1:0] = i_ex_rd_code;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sb_vld_q  <= '0;
      sb_code_q <= '0;
    end else begin
      sb_vld_q  <= sb_vld_d;
      sb_code_q <= sb_code_d;
    end
  end

  // Flush sequencer: cycle of the PC write plus FLUSH_CYCLES-1 more cycles.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_pc_en && UseSeq) begin
            state_q <= StFlush;
            cnt_q   <= CntLoad;
          end
        end
        StFlush: begin
          if (i_pc_en)            cnt_q   <= CntLoad;
          else if (cnt_q == 4'd0) state_q <= StIdle;
          else                    cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                 irq_pend_q <= 1'b0;
    else if (irq_take)            irq_pend_q <= 1'b0;
    else if (i_irq_flag && hold)  irq_pend_q <= 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
module tb_hazard_ctrl_sb;

  localparam int WB_DEPTH     = 2;
  localparam int NUM_SRC      = 3;
  localparam int NUM_HOLD     = 2;
  localparam int FLUSH_CYCLES = 3;
  localparam int FW           = $clog2(WB_DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n, irq_flag, pc_en, rd_vld;
  logic [3:0]           rd_code;
  logic [4*NUM_SRC-1:0] src_code;
  logic [NUM_SRC-1:0]   src_vld;
  logic [NUM_HOLD-1:0]  hold_req;
  logic id_flush, ex_flush, bubble, phold, irq_take;
`ifdef HAZARD_FWD_EN
  logic [NUM_SRC*FW-1:0] fwd_sel;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: list of pending writes (index 0 youngest),
  // remaining extra flush cycles, and a deferred IRQ flag.
  bit       m_vld[WB_DEPTH];
  bit [3:0] m_code[WB_DEPTH];
  int       m_rem;
  bit       m_pend;

  // Last sampled outputs, for directed counting.
  bit s_idf, s_exf, s_bub, s_hold, s_take;

  always #5 clk = ~clk;

  hazard_ctrl_sb #(
    .WB_DEPTH     (WB_DEPTH),
    .NUM_SRC      (NUM_SRC),
    .NUM_HOLD     (NUM_HOLD),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_irq_flag     (irq_flag),
    .i_pc_en        (pc_en),
    .i_ex_rd_vld    (rd_vld),
    .i_ex_rd_code   (rd_code),
    .i_src_code     (src_code),
    .i_src_vld      (src_vld),
    .i_hold_req     (hold_req),
`ifdef HAZARD_FWD_EN
    .o_fwd_sel      (fwd_sel),
`endif
    .o_id_flush     (id_flush),
    .o_ex_flush     (ex_flush),
    .o_bubble       (bubble),
    .o_pipelinehold (phold),
    .o_irq_take     (irq_take)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    rst_n = 1'b1; irq_flag = 1'b0; pc_en = 1'b0; rd_vld = 1'b0; rd_code = 4'd0;
    src_code = '0; src_vld = '0; hold_req = '0;
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model
  // at the rising edge together with the DUT.
  task automatic step();
    bit h, fl, hzd, hzw, tk, exf, bub;
    int fwd_exp[NUM_SRC];
    @(negedge clk);
    h   = |hold_req;
    fl  = pc_en || (m_rem > 0);
    hzd = 1'b0;
    hzw = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      fwd_exp[k] = 0;
      for (int j = 0; j < WB_DEPTH; j++) begin
        if (src_vld[k] && m_vld[j] && m_code[j] == src_code[4*k +: 4]) begin
`ifdef HAZARD_FWD_EN
          if (j == 0) hzd = 1'b1;
          else if (fwd_exp[k] == 0) fwd_exp[k] = j + 1;
`else
          hzd = 1'b1;
`endif
        end
      end
    end
    for (int j = 0; j < WB_DEPTH; j++) if (m_vld[j] && m_code[j] == 4'hF) hzw = 1'b1;
    tk  = (irq_flag || m_pend) && !h && !fl;
    exf = fl || hzw || hzd || tk || h;
    bub = hzd && !fl;
    if (!rst_n) begin
      fl = 0; exf = 0; bub = 0; h = 0; tk = 0;
      for (int k = 0; k < NUM_SRC; k++) fwd_exp[k] = 0;
    end
    check_eq("id_flush", 32'(id_flush), 32'(fl));
    check_eq("ex_flush", 32'(ex_flush), 32'(exf));
    check_eq("bubble", 32'(bubble), 32'(bub));
    check_eq("pipelinehold", 32'(phold), 32'(h));
    check_eq("irq_take", 32'(irq_take), 32'(tk));
`ifdef HAZARD_FWD_EN
    for (int k = 0; k < NUM_SRC; k++) check_eq("fwd_sel", 32'(fwd_sel[k*FW +: FW]), 32'(fwd_exp[k]));
`endif
    s_idf = id_flush; s_exf = ex_flush; s_bub = bubble; s_hold = phold; s_take = irq_take;
    @(posedge clk);
    if (!rst_n) begin
      for (int j = 0; j < WB_DEPTH; j++) begin m_vld[j] = 0; m_code[j] = 0; end
      m_rem = 0; m_pend = 0;
    end else begin
      if (!h) begin
        for (int j = WB_DEPTH - 1; j > 0; j--) begin
          m_vld[j] = m_vld[j-1]; m_code[j] = m_code[j-1];
        end
        m_vld[0]  = rd_vld && !exf;
        m_code[0] = rd_code;
      end
      if (pc_en) m_rem = FLUSH_CYCLES - 1;
      else if (m_rem > 0) m_rem--;
      if (tk) m_pend = 0;
      else if (irq_flag && h) m_pend = 1;
    end
    #1;
  endtask

  function automatic logic [3:0] rand_code();
    int r = $urandom_range(0, 6);
    return (r == 6) ? 4'hF : 4'(r);
  endfunction

  task automatic randomize_inputs();
    irq_flag = ($urandom_range(0, 3) == 0);
    pc_en    = ($urandom_range(0, 7) == 0);
    rd_vld   = $urandom_range(0, 1);
    rd_code  = rand_code();
    for (int k = 0; k < NUM_SRC; k++) src_code[4*k +: 4] = rand_code();
    src_vld  = NUM_SRC'($urandom);
    hold_req = ($urandom_range(0, 3) == 0) ? NUM_HOLD'($urandom) : '0;
  endtask

  initial begin
    int cnt_a, cnt_b;
    for (int j = 0; j < WB_DEPTH; j++) begin m_vld[j] = 0; m_code[j] = 0; end
    m_rem = 0; m_pend = 0;
    idle();
    rst_n = 1'b0;
    #1;

    // 1. Reset with random inputs, then a quiet cycle.
    for (int i = 0; i < 2; i++) begin randomize_inputs(); rst_n = 1'b0; step(); end
    idle(); step();
    check_eq("reset_exf", 32'(s_exf), 32'd0);

    // 2. RAW hazard on r3.
    rd_vld = 1; rd_code = 4'd3; step();
    idle(); src_code[3:0] = 4'd3; src_vld = 3'b001;
    cnt_a = 0;
    for (int i = 0; i < 4; i++) begin step(); cnt_a += int'(s_bub); end
`ifdef HAZARD_FWD_EN
    check_eq("raw_bubble_cycles", 32'(cnt_a), 32'd1);
`else
    check_eq("raw_bubble_cycles", 32'(cnt_a), 32'd2);
`endif

    // 3. Branch flush length, then a restart in the middle.
    idle(); pc_en = 1; step(); idle();
    cnt_a = int'(s_idf);
    for (int i = 0; i < 5; i++) begin step(); cnt_a += int'(s_idf); end
    check_eq("flush_len", 32'(cnt_a), 32'd3);
    pc_en = 1; step(); idle(); cnt_a = int'(s_idf);
    step(); cnt_a += int'(s_idf);
    pc_en = 1; step(); idle(); cnt_a += int'(s_idf);
    for (int i = 0; i < 5; i++) begin step(); cnt_a += int'(s_idf); end
    check_eq("flush_restart_len", 32'(cnt_a), 32'd5);

    // 4. Hold with r5 in sb[0]; scoreboard must stay frozen.
    rd_vld = 1; rd_code = 4'd5; step();
    idle(); hold_req = 2'b10; rd_vld = 1; rd_code = 4'd7;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 4; i++) begin step(); cnt_a += int'(s_hold); cnt_b += int'(s_exf); end
    check_eq("hold_cycles", 32'(cnt_a), 32'd4);
    check_eq("hold_exf_cycles", 32'(cnt_b), 32'd4);
    idle(); src_code[3:0] = 4'd5; src_vld = 3'b001; step();
    check_eq("hold_sb0_kept", 32'(s_bub), 32'd1);
    idle(); step(); step();

    // 5. IRQ raised in hold cycle 2 is taken on the first free cycle.
    cnt_a = 0;
    for (int i = 0; i < 4; i++) begin
      idle(); hold_req = 2'b01; irq_flag = (i == 1); step(); cnt_a += int'(s_take);
    end
    check_eq("irq_in_hold", 32'(cnt_a), 32'd0);
    idle(); step();
    check_eq("irq_deferred_take", 32'(s_take), 32'd1);
    step();
    check_eq("irq_single_pulse", 32'(s_take), 32'd0);

    // 6. Write to PC in flight.
    idle(); rd_vld = 1; rd_code = 4'hF; step();
    idle(); cnt_a = 0;
    for (int i = 0; i < 3; i++) begin step(); cnt_a += int'(s_exf); end
    check_eq("pc_write_exf_cycles", 32'(cnt_a), 32'd2);
    rd_vld = 1; rd_code = 4'd4; step();
    idle(); step();
    src_code[3:0] = 4'd4; src_vld = 3'b001; step();
`ifdef HAZARD_FWD_EN
    check_eq("fwd_no_bubble", 32'(s_bub), 32'd0);
`else
    check_eq("sb1_bubble", 32'(s_bub), 32'd1);
`endif

    // Random traffic against the model, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      rst_n = ($urandom_range(0, 60) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
